// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and encodings for the 16-bit RISC controller:
//               state enum, opcode/op fields, writeback select, memory
//               command and PC source codes. Branch condition codes exist
//               only when CPU_BRANCH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [4:0] {
        S_RST     = 5'd0,
        S_IF1     = 5'd1,
        S_IF2     = 5'd2,
        S_UPD_PC  = 5'd3,
        S_DECODE  = 5'd4,
        S_WR_IMM  = 5'd5,
        S_GET_A   = 5'd6,
        S_GET_B   = 5'd7,
        S_EXEC    = 5'd8,
        S_WR_C    = 5'd9,
        S_ADDR    = 5'd10,
        S_LD_ADDR = 5'd11,
        S_MRD     = 5'd12,
        S_WR_M    = 5'd13,
        S_ST_B    = 5'd14,
        S_ST_C    = 5'd15,
        S_MWR     = 5'd16,
        S_BRANCH  = 5'd17,
        S_HALT    = 5'd18
    } state_t;

    localparam logic [2:0] c_OPC_MOV = 3'b110;
    localparam logic [2:0] c_OPC_ALU = 3'b101;
    localparam logic [2:0] c_OPC_LDR = 3'b011;
    localparam logic [2:0] c_OPC_STR = 3'b100;

    localparam logic [1:0] c_OP_MOVI = 2'b10;
    localparam logic [1:0] c_OP_MOVR = 2'b00;
    localparam logic [1:0] c_OP_ADD  = 2'b00;
    localparam logic [1:0] c_OP_CMP  = 2'b01;
    localparam logic [1:0] c_OP_MVN  = 2'b11;
    localparam logic [1:0] c_OP_MEM  = 2'b00;

    localparam logic [3:0] c_VSEL_C     = 4'b0001;
    localparam logic [3:0] c_VSEL_IMM   = 4'b0100;
    localparam logic [3:0] c_VSEL_MDATA = 4'b1000;

    localparam logic [1:0] c_MEM_NONE  = 2'b00;
    localparam logic [1:0] c_MEM_READ  = 2'b01;
    localparam logic [1:0] c_MEM_WRITE = 2'b10;

    localparam logic [1:0] c_PC_INC  = 2'b00;
    localparam logic [1:0] c_PC_REL  = 2'b01;
    localparam logic [1:0] c_PC_ZERO = 2'b10;

`ifdef CPU_BRANCH_EN
    localparam logic [2:0] c_OPC_BR   = 3'b001;
    localparam logic [1:0] c_OP_BR    = 2'b00;
    localparam logic [2:0] c_COND_B   = 3'b000;
    localparam logic [2:0] c_COND_BEQ = 3'b001;
    localparam logic [2:0] c_COND_BNE = 3'b010;
    localparam logic [2:0] c_COND_BLT = 3'b011;
    localparam logic [2:0] c_COND_BLE = 3'b100;
`endif

endpackage
`default_nettype wire

// File: rtl/instr_field_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_field_decode
// Description : Combinational split of the instruction word into its fields
//               plus sign extension of the 5- and 8-bit immediates.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_field_decode #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] ir,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic [2:0]        rn,
    output logic [2:0]        rd,
    output logic [1:0]        sh,
    output logic [2:0]        rm,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

endmodule
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_fsm
// Description : Moore controller for the 16-bit RISC datapath: fetch, decode
//               and per-instruction sequencing of datapath and memory control.
//               Define CPU_BRANCH_EN to decode the conditional branch group.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int PC_W   = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] ir,
    input  logic [2:0]        flags,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic [3:0]        vsel,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8,
    output logic              load_ir,
    output logic              load_pc,
    output logic [1:0]        pc_src,
    output logic              load_addr,
    output logic              addr_sel,
    output logic [1:0]        mem_cmd,
    output logic              halted
);

    generate
        if (PC_W < 1 || PC_W > DATA_W) begin : g_bad_pc_w
            $error("PC_W must lie between 1 and DATA_W");
        end
    endgenerate

    state_t     r_state;
    state_t     w_next;
    state_t     w_decode_next;
    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;

    instr_field_decode #(
        .DATA_W (DATA_W)
    ) u_fields (
        .ir     (ir),
        .opcode (w_opcode),
        .op     (w_op),
        .rn     (w_rn),
        .rd     (w_rd),
        .sh     (w_sh),
        .rm     (w_rm),
        .sximm5 (sximm5),
        .sximm8 (sximm8)
    );

`ifdef CPU_BRANCH_EN
    // Branch condition sits in the Rn field; unknown conditions halt.
    logic w_cond_ok;
    logic w_taken;
    always_comb begin
        w_cond_ok = 1'b1;
        w_taken   = 1'b0;
        case (w_rn)
            c_COND_B:   w_taken = 1'b1;
            c_COND_BEQ: w_taken = flags[0];
            c_COND_BNE: w_taken = ~flags[0];
            c_COND_BLT: w_taken = flags[1] ^ flags[2];
            c_COND_BLE: w_taken = (flags[1] ^ flags[2]) | flags[0];
            default:    w_cond_ok = 1'b0;
        endcase
    end
`else
    logic w_unused_flags;
    assign w_unused_flags = ^flags;
`endif

    always_comb begin
        w_decode_next = S_HALT;
        case (w_opcode)
            c_OPC_MOV: begin
                if (w_op == c_OP_MOVI)
                    w_decode_next = S_WR_IMM;
                else if (w_op == c_OP_MOVR)
                    w_decode_next = S_GET_B;
            end
            c_OPC_ALU: w_decode_next = (w_op == c_OP_MVN) ? S_GET_B : S_GET_A;
            c_OPC_LDR, c_OPC_STR: begin
                if (w_op == c_OP_MEM)
                    w_decode_next = S_GET_A;
            end
`ifdef CPU_BRANCH_EN
            c_OPC_BR: begin
                if (w_op == c_OP_BR && w_cond_ok)
                    w_decode_next = S_BRANCH;
            end
`endif
            default: w_decode_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_RST;
        else
            r_state <= w_next;
    end

    always_comb begin
        readnum   = 3'd0;
        writenum  = 3'd0;
        write     = 1'b0;
        vsel      = 4'b0000;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        shift     = 2'b00;
        ALUop     = 2'b00;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        pc_src    = c_PC_INC;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = c_MEM_NONE;
        halted    = 1'b0;
        w_next    = S_HALT;
        case (r_state)
            S_RST: begin
                load_pc = 1'b1;
                pc_src  = c_PC_ZERO;
                w_next  = S_IF1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = c_MEM_READ;
                w_next   = S_IF2;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = c_MEM_READ;
                load_ir  = 1'b1;
                w_next   = S_UPD_PC;
            end
            S_UPD_PC: begin
                load_pc = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: w_next = w_decode_next;
            S_WR_IMM: begin
                vsel     = c_VSEL_IMM;
                writenum = w_rn;
                write    = 1'b1;
                w_next   = S_IF1;
            end
            S_GET_A: begin
                readnum = w_rn;
                loada   = 1'b1;
                w_next  = (w_opcode == c_OPC_ALU) ? S_GET_B : S_ADDR;
            end
            S_GET_B: begin
                readnum = w_rm;
                loadb   = 1'b1;
                w_next  = S_EXEC;
            end
            S_EXEC: begin
                // MOV reuses the adder with A forced to zero.
                shift = w_sh;
                if (w_opcode == c_OPC_MOV) begin
                    asel  = 1'b1;
                    ALUop = c_OP_ADD;
                end else begin
                    ALUop = w_op;
                end
                if (w_opcode == c_OPC_ALU && w_op == c_OP_CMP) begin
                    loads  = 1'b1;
                    w_next = S_IF1;
                end else begin
                    loadc  = 1'b1;
                    w_next = S_WR_C;
                end
            end
            S_WR_C: begin
                vsel     = c_VSEL_C;
                writenum = w_rd;
                write    = 1'b1;
                w_next   = S_IF1;
            end
            S_ADDR: begin
                bsel   = 1'b1;
                ALUop  = c_OP_ADD;
                loadc  = 1'b1;
                w_next = S_LD_ADDR;
            end
            S_LD_ADDR: begin
                load_addr = 1'b1;
                w_next    = (w_opcode == c_OPC_LDR) ? S_MRD : S_ST_B;
            end
            S_MRD: begin
                mem_cmd = c_MEM_READ;
                w_next  = S_WR_M;
            end
            S_WR_M: begin
                mem_cmd  = c_MEM_READ;
                vsel     = c_VSEL_MDATA;
                writenum = w_rd;
                write    = 1'b1;
                w_next   = S_IF1;
            end
            S_ST_B: begin
                readnum = w_rd;
                loadb   = 1'b1;
                w_next  = S_ST_C;
            end
            S_ST_C: begin
                asel   = 1'b1;
                ALUop  = c_OP_ADD;
                loadc  = 1'b1;
                w_next = S_MWR;
            end
            S_MWR: begin
                mem_cmd = c_MEM_WRITE;
                w_next  = S_IF1;
            end
`ifdef CPU_BRANCH_EN
            S_BRANCH: begin
                if (w_taken) begin
                    load_pc = 1'b1;
                    pc_src  = c_PC_REL;
                end
                w_next = S_IF1;
            end
`endif
            S_HALT: begin
                halted = 1'b1;
                w_next = S_HALT;
            end
            default: w_next = S_HALT;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_fsm
// Description : Self-checking bench: directed vector table, reset/halt
//               sequences and random instructions against a trace model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_fsm;

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       load_ir;
        logic       load_pc;
        logic [1:0] pc_src;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       halted;
    } out_t;

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  flags;
        int          idx;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] ir;
    logic [2:0]  flags;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [3:0]  vsel;
    logic [1:0]  shift, aluop, pc_src, mem_cmd;
    logic [15:0] sximm5, sximm8;
    logic        load_ir, load_pc, load_addr, addr_sel, halted;

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t exp_q[$];
    out_t rst_exp;
    vec_t tv[12];

    always #5 clk = ~clk;

    cpu_control_fsm #(.PC_W(9), .DATA_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .ir(ir), .flags(flags),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(aluop),
        .sximm5(sximm5), .sximm8(sximm8), .load_ir(load_ir), .load_pc(load_pc),
        .pc_src(pc_src), .load_addr(load_addr), .addr_sel(addr_sel),
        .mem_cmd(mem_cmd), .halted(halted)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic out_t sample();
        out_t o;
        o.readnum = readnum;   o.writenum = writenum; o.write = write;
        o.vsel = vsel;         o.loada = loada;       o.loadb = loadb;
        o.loadc = loadc;       o.loads = loads;       o.asel = asel;
        o.bsel = bsel;         o.shift = shift;       o.aluop = aluop;
        o.load_ir = load_ir;   o.load_pc = load_pc;   o.pc_src = pc_src;
        o.load_addr = load_addr; o.addr_sel = addr_sel; o.mem_cmd = mem_cmd;
        o.halted = halted;
        return o;
    endfunction

    task automatic check(input string nm, input int c, input out_t a, input out_t e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", nm, c, a, e);
        end
    endtask

    // Expected per-cycle outputs of one instruction, listed step by step.
    function automatic bit model(input logic [15:0] i, input logic [2:0] f);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        out_t o, rda, rdb, wrc;
        bit   halt;
        bit   z, n, v, taken;
        opc = i[15:13]; op = i[12:11]; rn = i[10:8];
        rd = i[7:5];    sh = i[4:3];   rm = i[2:0];
        z = f[0]; n = f[1]; v = f[2];
        halt = 1'b0;
        exp_q.delete();
        o = '0; o.addr_sel = 1'b1; o.mem_cmd = 2'b01; exp_q.push_back(o);
        o.load_ir = 1'b1; exp_q.push_back(o);
        o = '0; o.load_pc = 1'b1; exp_q.push_back(o);
        o = '0; exp_q.push_back(o);
        rda = '0; rda.readnum = rn; rda.loada = 1'b1;
        rdb = '0; rdb.readnum = rm; rdb.loadb = 1'b1;
        wrc = '0; wrc.vsel = 4'b0001; wrc.writenum = rd; wrc.write = 1'b1;
        if (opc == 3'b110 && op == 2'b10) begin
            o = '0; o.vsel = 4'b0100; o.writenum = rn; o.write = 1'b1; exp_q.push_back(o);
        end else if (opc == 3'b110 && op == 2'b00) begin
            exp_q.push_back(rdb);
            o = '0; o.asel = 1'b1; o.shift = sh; o.loadc = 1'b1; exp_q.push_back(o);
            exp_q.push_back(wrc);
        end else if (opc == 3'b101) begin
            if (op != 2'b11) exp_q.push_back(rda);
            exp_q.push_back(rdb);
            o = '0; o.aluop = op; o.shift = sh;
            if (op == 2'b01) o.loads = 1'b1; else o.loadc = 1'b1;
            exp_q.push_back(o);
            if (op != 2'b01) exp_q.push_back(wrc);
        end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
            exp_q.push_back(rda);
            o = '0; o.bsel = 1'b1; o.loadc = 1'b1; exp_q.push_back(o);
            o = '0; o.load_addr = 1'b1; exp_q.push_back(o);
            if (opc == 3'b011) begin
                o = '0; o.mem_cmd = 2'b01; exp_q.push_back(o);
                o.vsel = 4'b1000; o.writenum = rd; o.write = 1'b1; exp_q.push_back(o);
            end else begin
                o = '0; o.readnum = rd; o.loadb = 1'b1; exp_q.push_back(o);
                o = '0; o.asel = 1'b1; o.loadc = 1'b1; exp_q.push_back(o);
                o = '0; o.mem_cmd = 2'b10; exp_q.push_back(o);
            end
`ifdef CPU_BRANCH_EN
        end else if (opc == 3'b001 && op == 2'b00 && rn <= 3'd4) begin
            case (rn)
                3'd0:    taken = 1'b1;
                3'd1:    taken = z;
                3'd2:    taken = !z;
                3'd3:    taken = (n != v);
                default: taken = (n != v) || z;
            endcase
            o = '0;
            if (taken) begin o.load_pc = 1'b1; o.pc_src = 2'b01; end
            exp_q.push_back(o);
`endif
        end else begin
            halt = 1'b1;
            o = '0; o.halted = 1'b1;
            for (int k = 0; k < 10; k++) exp_q.push_back(o);
        end
        return halt;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1 check("reset_async", 0, sample(), rst_exp);
        @(negedge clk);
        #1 check("reset_hold", 1, sample(), rst_exp);
        reset_n = 1'b1;
    endtask

    task automatic run_instr(input logic [15:0] i, input logic [2:0] f, input int stop_at,
                             input int vidx, input out_t vexp, input string nm);
        bit   h;
        int   n_cyc;
        int   v5, v8;
        out_t a;
        h = model(i, f);
        n_cyc = (stop_at < exp_q.size()) ? stop_at : exp_q.size();
        for (int c = 0; c < n_cyc; c++) begin
            @(negedge clk);
            if (c == 0) begin
                ir = i;
                flags = f;
            end
            #1;
            a = sample();
            check(nm, c, a, exp_q[c]);
            if (c == vidx) check({nm, "_vec"}, c, a, vexp);
            if (c == 0) begin
                v5 = int'(i[4:0]); if (v5 > 15)  v5 -= 32;
                v8 = int'(i[7:0]); if (v8 > 127) v8 -= 256;
                n_checks++;
                if (sximm5 !== 16'(v5) || sximm8 !== 16'(v8)) begin
                    n_fail++;
                    $display("FAIL %s_sximm got=%h/%h exp=%h/%h", nm, sximm5, sximm8,
                             16'(v5), 16'(v8));
                end
            end
        end
        if (h || stop_at < exp_q.size()) do_reset();
    endtask

    initial begin
        logic [15:0] ri;
        logic [10:0] lo;
        int          kind;
        reset_n = 1'b0;
        ir      = '0;
        flags   = '0;
        rst_exp = '0; rst_exp.load_pc = 1'b1; rst_exp.pc_src = 2'b10;

        for (int k = 0; k < 12; k++) begin tv[k].flags = 3'b000; tv[k].exp = '0; end
        tv[0].ir = 16'hD207; tv[0].idx = 4;
        tv[0].exp.writenum = 3'd2; tv[0].exp.vsel = 4'b0100; tv[0].exp.write = 1'b1;
        tv[1].ir = 16'hA0C1; tv[1].idx = 4; tv[1].exp.readnum = 3'd0; tv[1].exp.loada = 1'b1;
        tv[2].ir = 16'hA0C1; tv[2].idx = 5; tv[2].exp.readnum = 3'd1; tv[2].exp.loadb = 1'b1;
        tv[3].ir = 16'hA0C1; tv[3].idx = 7;
        tv[3].exp.writenum = 3'd6; tv[3].exp.vsel = 4'b0001; tv[3].exp.write = 1'b1;
        tv[4].ir = 16'hA800; tv[4].idx = 6; tv[4].exp.loads = 1'b1; tv[4].exp.aluop = 2'b01;
        tv[5].ir = 16'h6041; tv[5].idx = 5; tv[5].exp.bsel = 1'b1; tv[5].exp.loadc = 1'b1;
        tv[6].ir = 16'h6041; tv[6].idx = 7; tv[6].exp.mem_cmd = 2'b01;
        tv[7].ir = 16'h6041; tv[7].idx = 8; tv[7].exp.mem_cmd = 2'b01;
        tv[7].exp.vsel = 4'b1000; tv[7].exp.writenum = 3'd2; tv[7].exp.write = 1'b1;
        tv[8].ir = 16'hE000; tv[8].idx = 13; tv[8].exp.halted = 1'b1;
        tv[9].ir = 16'h8041; tv[9].idx = 9; tv[9].exp.mem_cmd = 2'b10;
        tv[10].ir = 16'hC069; tv[10].idx = 5;
        tv[10].exp.asel = 1'b1; tv[10].exp.shift = 2'b01; tv[10].exp.loadc = 1'b1;
        tv[11].ir = 16'h2103; tv[11].flags = 3'b001; tv[11].idx = 4;
`ifdef CPU_BRANCH_EN
        tv[11].exp.load_pc = 1'b1; tv[11].exp.pc_src = 2'b01;
`else
        tv[11].exp.halted = 1'b1;
`endif

        @(negedge clk);
        #1 check("reset", 0, sample(), rst_exp);
        @(negedge clk);
        #1 check("reset_release", 0, sample(), rst_exp);
        reset_n = 1'b1;

        for (int k = 0; k < 12; k++)
            run_instr(tv[k].ir, tv[k].flags, 1000, tv[k].idx, tv[k].exp,
                      $sformatf("vec%0d", k));

        // BEQ not taken: no PC update in the branch cycle.
        run_instr(16'h2103, 3'b000, 1000, -1, '0, "beq_not_taken");
        // Reset landing in the middle of a load aborts it cleanly.
        run_instr(16'h6041, 3'b000, 7, -1, '0, "ldr_abort");
        run_instr(16'hD207, 3'b000, 1000, -1, '0, "after_abort");

        for (int r = 0; r < 200; r++) begin
            kind = int'($urandom_range(0, 9));
            lo   = 11'($urandom);
            case (kind)
                0: ri = {3'b110, 2'b10, lo};
                1: ri = {3'b110, 2'b00, lo};
                2, 3, 4, 5: ri = {3'b101, 2'(kind - 2), lo};
                6: ri = {3'b011, 2'b00, lo};
                7: ri = {3'b100, 2'b00, lo};
                8: ri = {3'b001, 2'b00, lo};
                default: ri = 16'($urandom);
            endcase
            run_instr(ri, 3'($urandom), 1000, -1, '0, $sformatf("rand_%h", ri));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
